inst_fetch_unit: RTL and testbench
==================================

INST_FETCH_UNIT -- requirements
Module: inst_fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning first fetch address after reset.
REQ-002 SHALL have parameter FIFO_DEPTH, default 2, meaning number of instruction buffer entries (fixed at 2 for this revision).
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port imem_req_valid  output  1  fetch request to instruction memory.
REQ-006 SHALL have port imem_req_addr  output  32  word-aligned fetch address.
REQ-007 SHALL have port imem_req_ready  input  1  memory accepts request.
REQ-008 SHALL have port imem_rsp_valid  input  1  fetched word returned.
REQ-009 SHALL have port imem_rsp_data  input  32  fetched instruction word.
REQ-010 SHALL have port redirect_valid  input  1  branch/jump redirect from execute.
REQ-011 SHALL have port redirect_pc  input  32  redirect target.
REQ-012 SHALL have port if_valid  output  1  instruction available to IF_ID.
REQ-013 SHALL have port if_inst  output  32  instruction word to IF_ID / decoder.
REQ-014 SHALL have port if_pc  output  32  address of if_inst.
REQ-015 SHALL have port id_ready  input  1  IF_ID accepts instruction.

Function
REQ-016 SHALL keep fetch PC register; request accepted when imem_req_valid && imem_req_ready; PC += 4 (mod 2^32, wraps 32'hFFFF_FFFC -> 0) on acceptance.
REQ-017 SHALL allow at most one outstanding request; response arrives >=1 cycle after acceptance, never same cycle.
REQ-018 SHALL use FSM: IDLE (none outstanding), WAIT (one outstanding, keep), DROP (one outstanding, discard).
REQ-019 SHALL assert imem_req_valid only in IDLE, redirect_valid=0, and fifo_count < FIFO_DEPTH (space reservation covers outstanding word).
REQ-020 SHALL hold imem_req_addr = PC and keep imem_req_valid stable until accepted unless redirect occurs.
REQ-021 Transitions: IDLE->WAIT on acceptance; WAIT->IDLE on imem_rsp_valid (word pushed with its request PC); WAIT->DROP on redirect_valid without same-cycle response; DROP->IDLE on imem_rsp_valid (word discarded).
REQ-022 SHALL, on redirect_valid: clear FIFO, PC <= {redirect_pc[31:2],2'b00}, suppress request that cycle; response arriving same cycle discarded, state IDLE.
REQ-023 Redirect in DROP SHALL update PC and remain DROP.
REQ-024 SHALL present FIFO head on if_inst/if_pc; if_valid = FIFO non-empty; pop on if_valid && id_ready.
REQ-025 Simultaneous push and pop SHALL keep count unchanged, preserve order; push never occurs when full.
REQ-026 Pop coinciding with redirect SHALL be ignored (FIFO cleared).
REQ-027 Outputs if_inst/if_pc SHALL be zero when FIFO empty.
REQ-028 Throughput: sustained 1 instruction per 2 cycles with 1-cycle memory latency and id_ready=1.

Reset
REQ-029 While rst=1: state IDLE, PC=RESET_PC, FIFO empty, imem_req_valid=0, imem_req_addr=RESET_PC, if_valid=0, if_inst=0, if_pc=0.
REQ-030 Reset mid-operation SHALL discard outstanding response and FIFO contents; first request asserted in first cycle after rst deasserts.
REQ-031 Response arriving in cycle rst=1 or first cycle after SHALL be ignored only if request predates reset (tracked via DROP entry on reset release not required: memory is reset concurrently).

Verification
REQ-032 Reset release, ready=1, 1-cycle latency, id_ready=1 -> requests at 0x0,0x4,0x8; if_pc sequence 0x0,0x4,0x8 with matching data.
REQ-033 id_ready=0 -> after 2 words buffered, imem_req_valid stays 0; id_ready=1 then pops 0x0 then 0x4, fetch resumes at 0x8.
REQ-034 Redirect to 0x100 while WAIT -> stale response dropped, FIFO empty, next request addr 0x100, next if_pc 0x100.
REQ-035 Redirect to 0x203 same cycle as response -> response dropped, next request addr 0x200.
REQ-036 imem_req_ready=0 for 3 cycles -> imem_req_addr held, single acceptance, PC advances once.
REQ-037 RESET_PC=32'hFFFF_FFFC -> fetches 0xFFFF_FFFC then 0x0000_0000.

Source files
------------

// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: sequential instruction fetch with a two-entry instruction buffer.
//   Keeps a fetch PC and issues at most one outstanding request to instruction
//   memory. Returned words are pushed, together with the PC they were fetched
//   from, into a small FIFO that feeds IF_ID. A redirect flushes the buffer and
//   reloads the PC. A request still in flight at redirect time is discarded when
//   its response arrives.
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   imem_req_valid/addr/ready       fetch request handshake (word-aligned address)
//   imem_rsp_valid/data             fetched word, at least one cycle after acceptance
//   redirect_valid/pc               branch/jump redirect from execute
//   if_valid/if_inst/if_pc, id_ready  FIFO head presented to IF_ID, popped on handshake
module inst_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  output logic [31:0] if_inst,
  output logic [31:0] if_pc,
  input  logic        id_ready
);

  typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

  localparam logic [1:0] DEPTH = 2'(FIFO_DEPTH);

  state_t      state, state_next;
  logic [31:0] pc;
  logic [31:0] req_pc;
  logic [31:0] buf_inst [2];
  logic [31:0] buf_pc   [2];
  logic        rd_ptr, wr_ptr;
  logic [1:0]  count;
  logic        accept, push, pop;

  // A request is only issued from IDLE with a free slot, so the buffer always
  // has room for the word that comes back.
  always_comb begin
    imem_req_valid = !rst && (state == IDLE) && !redirect_valid && (count < DEPTH);
    imem_req_addr  = rst ? RESET_PC : pc;
    if_valid       = !rst && (count != 2'd0);
    if_inst        = if_valid ? buf_inst[rd_ptr] : '0;
    if_pc          = if_valid ? buf_pc[rd_ptr]   : '0;
  end

  assign accept = imem_req_valid && imem_req_ready;
  assign push   = (state == WAIT) && imem_rsp_valid && !redirect_valid;
  assign pop    = if_valid && id_ready && !redirect_valid;

  // A response always returns the FSM to IDLE, even when it coincides with a
  // redirect; a redirect without a response turns a live request into a dead one.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) state_next = WAIT;
      WAIT: begin
        if (imem_rsp_valid)      state_next = IDLE;
        else if (redirect_valid) state_next = DROP;
      end
      DROP: if (imem_rsp_valid) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      pc     <= RESET_PC;
      req_pc <= RESET_PC;
      count  <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
    end else begin
      state <= state_next;
      if (redirect_valid)
        pc <= redirect_pc & ~32'd3;
      else if (accept)
        pc <= pc + 32'd4;
      if (accept)
        req_pc <= pc;
      if (redirect_valid) begin
        count  <= '0;
        rd_ptr <= 1'b0;
        wr_ptr <= 1'b0;
      end else begin
        if (push) wr_ptr <= ~wr_ptr;
        if (pop)  rd_ptr <= ~rd_ptr;
        case ({push, pop})
          2'b10:   count <= count + 2'd1;
          2'b01:   count <= count - 2'd1;
          default: count <= count;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push) begin
      buf_inst[wr_ptr] <= imem_rsp_data;
      buf_pc[wr_ptr]   <= req_pc;
    end
  end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// tb_inst_fetch_unit: randomized scoreboard bench for inst_fetch_unit.
//   The driver models instruction memory and the expected instruction stream
//   (sequential PCs, flushed on redirect/reset); expected words go into a queue
//   that the monitor pops whenever IF_ID takes an instruction. A second instance
//   with RESET_PC at the top of the address space checks PC wrap-around.
module tb_inst_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid, imem_req_ready, imem_rsp_valid;
  logic [31:0] imem_req_addr, imem_rsp_data;
  logic        redirect_valid, id_ready, if_valid;
  logic [31:0] redirect_pc, if_inst, if_pc;

  logic        req2_valid, ready2, rsp2_valid, redir2, if2_valid, idr2;
  logic [31:0] req2_addr, rsp2_data, rpc2, if2_inst, if2_pc;

  always #5 clk = ~clk;

  inst_fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
    .imem_req_ready(imem_req_ready), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .if_valid(if_valid), .if_inst(if_inst),
    .if_pc(if_pc), .id_ready(id_ready)
  );

  inst_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst(rst),
    .imem_req_valid(req2_valid), .imem_req_addr(req2_addr),
    .imem_req_ready(ready2), .imem_rsp_valid(rsp2_valid),
    .imem_rsp_data(rsp2_data), .redirect_valid(redir2),
    .redirect_pc(rpc2), .if_valid(if2_valid), .if_inst(if2_inst),
    .if_pc(if2_pc), .id_ready(idr2)
  );

  int n_cmp = 0;
  int n_err = 0;

  logic [63:0] exp_q[$];   // {pc, inst} expected at IF_ID, in order

  task automatic check(input bit ok, input string name,
                       input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory / reference model state
  logic [31:0] model_pc;
  bit          pending, drop, rsp_now;
  logic [31:0] pend_pc, pend_data;
  int          lat;

  task automatic run_phase(input int cycles, input int rdy_pct, input int idr_pct,
                           input int redir_pct, input int maxlat, input bit do_rst);
    bit exp_rv;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      rst            = do_rst;
      imem_req_ready = ($urandom_range(99) < rdy_pct);
      id_ready       = ($urandom_range(99) < idr_pct);
      redirect_valid = !do_rst && ($urandom_range(99) < redir_pct);
      redirect_pc    = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | $urandom_range(15))
                                                : ($urandom & 32'h0000_0FFF);
      rsp_now = pending && (lat == 1);
      if (pending) lat--;
      if (do_rst) imem_rsp_valid = ($urandom_range(1) == 1);
      else        imem_rsp_valid = rsp_now;
      imem_rsp_data = rsp_now ? pend_data : $urandom;
      #2;
      if (do_rst) begin
        check(!imem_req_valid, "rst_req_valid", 32'(imem_req_valid), 32'd0);
        check(imem_req_addr == 32'h0, "rst_req_addr", imem_req_addr, 32'h0);
        check(!if_valid, "rst_if_valid", 32'(if_valid), 32'd0);
        check(if_inst == 32'h0 && if_pc == 32'h0, "rst_if_zero", if_inst | if_pc, 32'h0);
        exp_q.delete();
        pending  = 0;
        drop     = 0;
        model_pc = 32'h0;
      end else begin
        exp_rv = !pending && !redirect_valid && (exp_q.size() < 2);
        check(imem_req_valid == exp_rv, "req_valid", 32'(imem_req_valid), 32'(exp_rv));
        if (exp_rv)
          check(imem_req_addr == model_pc, "req_addr", imem_req_addr, model_pc);
        check(if_valid == (exp_q.size() != 0), "if_valid", 32'(if_valid), 32'(exp_q.size() != 0));
        if (redirect_valid) begin
          exp_q.delete();
          model_pc = redirect_pc & ~32'd3;
          if (pending) begin
            if (rsp_now) pending = 0;
            else         drop = 1;
          end
        end else begin
          if (rsp_now) begin
            if (!drop) exp_q.push_back({pend_pc, pend_data});
            pending = 0;
          end
          if (exp_rv && imem_req_ready) begin
            pending   = 1;
            drop      = 0;
            pend_pc   = model_pc;
            pend_data = $urandom;
            lat       = $urandom_range(maxlat, 1);
            model_pc  = model_pc + 32'd4;
          end
        end
      end
    end
  endtask

  // Monitor: consumes expected words when IF_ID takes an instruction.
  initial begin
    logic [63:0] e;
    forever begin
      @(negedge clk);
      #3;
      if (!rst) begin
        if (!if_valid) begin
          check(if_inst == 32'h0 && if_pc == 32'h0, "empty_zero", if_inst | if_pc, 32'h0);
        end else if (id_ready && !redirect_valid) begin
          if (exp_q.size() == 0) begin
            check(1'b0, "pop_unexpected", if_pc, 32'h0);
          end else begin
            e = exp_q.pop_front();
            check(if_pc == e[63:32], "if_pc", if_pc, e[63:32]);
            check(if_inst == e[31:0], "if_inst", if_inst, e[31:0]);
          end
        end
      end
    end
  end

  // Wrap-around instance: always-ready memory with 1-cycle latency.
  initial begin
    bit          pend2 = 0;
    logic [31:0] pend2_addr = '0;
    logic [31:0] exp2_req = 32'hFFFF_FFFC;
    logic [31:0] exp2_out = 32'hFFFF_FFFC;
    int          n2 = 0;
    ready2 = 1'b1; idr2 = 1'b1; redir2 = 1'b0; rpc2 = '0;
    rsp2_valid = 1'b0; rsp2_data = '0;
    forever begin
      @(negedge clk);
      rsp2_valid = pend2;
      rsp2_data  = pend2_addr ^ 32'hDEAD_BEEF;
      #2;
      if (rst) begin
        pend2 = 0; n2 = 0;
        exp2_req = 32'hFFFF_FFFC;
        exp2_out = 32'hFFFF_FFFC;
      end else begin
        if (if2_valid && n2 < 4) begin
          check(if2_pc == exp2_out, "wrap_if_pc", if2_pc, exp2_out);
          check(if2_inst == (exp2_out ^ 32'hDEAD_BEEF), "wrap_if_inst", if2_inst,
                exp2_out ^ 32'hDEAD_BEEF);
          exp2_out = exp2_out + 32'd4;
          n2++;
        end
        if (req2_valid) begin
          if (n2 < 4) check(req2_addr == exp2_req, "wrap_req_addr", req2_addr, exp2_req);
          exp2_req   = exp2_req + 32'd4;
          pend2      = 1;
          pend2_addr = req2_addr;
        end else begin
          pend2 = 0;
        end
      end
    end
  end

  initial begin
    rst = 1'b1; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    redirect_valid = 1'b0; redirect_pc = '0; id_ready = 1'b0;
    pending = 0; drop = 0; rsp_now = 0; lat = 0;
    pend_pc = '0; pend_data = '0; model_pc = '0;
    //        cycles rdy idr redir lat rst
    run_phase(3,   100, 100, 0,  1, 1'b1);
    run_phase(12,  100, 100, 0,  1, 1'b0);   // streaming fetch from 0
    run_phase(10,  100, 0,   0,  1, 1'b0);   // IF_ID stalled: buffer fills
    run_phase(8,   100, 100, 0,  1, 1'b0);   // drain and resume
    run_phase(20,  25,  100, 0,  2, 1'b0);   // memory backpressure
    run_phase(300, 70,  60,  8,  3, 1'b0);   // random mix with redirects
    run_phase(2,   50,  50,  0,  2, 1'b1);   // reset mid-operation
    run_phase(200, 80,  70,  12, 3, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
